// File: rtl/gemm_loop_seq.sv
// ---------------------------------------------------------------------------
// gemm_loop_seq
//   Issue side of the GEMM index path. Accepts one 128-bit GEMM instruction
//   and walks its loop nest iter_out x iter_in x [uop_bgn, uop_end), emitting
//   one beat per micro-op with the uop address and the six loop offsets.
//   Offsets are accumulated by addition (no multipliers) and wrap modulo
//   2^width.
//
// Ports
//   clk, rst_n         clock, asynchronous active-low reset
//   insn_valid/ready   instruction handshake (ready only in IDLE)
//   insn[127:0]        packed GEMM instruction
//   out_valid/ready    beat handshake
//   uop_addr           uop index for this beat
//   dst/src/wgt_offset_out/in  outer/inner loop offsets
//   reset_acc          latched reset_reg bit of the instruction
//   last               final beat of the instruction
//   done               one-cycle pulse after the final beat
// ---------------------------------------------------------------------------
module gemm_loop_seq #(
  parameter logic [2:0] OPCODE_GEMM = 3'd2,
  parameter int         UOP_AW      = 14,
  parameter int         DST_W       = 11,
  parameter int         SRC_W       = 11,
  parameter int         WGT_W       = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              insn_valid,
  output logic              insn_ready,
  input  logic [127:0]      insn,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [UOP_AW-1:0] uop_addr,
  output logic [DST_W-1:0]  dst_offset_out,
  output logic [DST_W-1:0]  dst_offset_in,
  output logic [SRC_W-1:0]  src_offset_out,
  output logic [SRC_W-1:0]  src_offset_in,
  output logic [WGT_W-1:0]  wgt_offset_out,
  output logic [WGT_W-1:0]  wgt_offset_in,
  output logic              reset_acc,
  output logic              last,
  output logic              done
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam logic [UOP_AW-1:0] UOP_ONE = UOP_AW'(1);
  localparam logic [13:0]       CNT_ONE = 14'd1;

  state_t state_q, state_d;

  logic [UOP_AW-1:0] uop_bgn_q, uop_bgn_d;
  logic [UOP_AW-1:0] uop_end_q, uop_end_d;
  logic [13:0]       iter_out_q, iter_out_d;
  logic [13:0]       iter_in_q, iter_in_d;
  logic [DST_W-1:0]  dst_f_out_q, dst_f_out_d, dst_f_in_q, dst_f_in_d;
  logic [SRC_W-1:0]  src_f_out_q, src_f_out_d, src_f_in_q, src_f_in_d;
  logic [WGT_W-1:0]  wgt_f_out_q, wgt_f_out_d, wgt_f_in_q, wgt_f_in_d;

  logic [UOP_AW-1:0] u_q, u_d;
  logic [13:0]       i_q, i_d;
  logic [13:0]       j_q, j_d;
  logic [DST_W-1:0]  dst_out_q, dst_out_d, dst_in_q, dst_in_d;
  logic [SRC_W-1:0]  src_out_q, src_out_d, src_in_q, src_in_d;
  logic [WGT_W-1:0]  wgt_out_q, wgt_out_d, wgt_in_q, wgt_in_d;
  logic              reset_acc_q, reset_acc_d;

  // Instruction field decode
  logic [2:0]        insn_op;
  logic [UOP_AW-1:0] insn_bgn, insn_end;
  logic [13:0]       insn_iter_out, insn_iter_in;
  logic              insn_degenerate;

  assign insn_op       = insn[2:0];
  assign insn_bgn      = UOP_AW'(insn[20:8]);
  assign insn_end      = UOP_AW'(insn[34:21]);
  assign insn_iter_out = insn[48:35];
  assign insn_iter_in  = insn[62:49];

  // Degenerate instructions go straight to DONE without emitting a beat.
  assign insn_degenerate = (insn_op != OPCODE_GEMM) || (insn_iter_out == 14'd0) ||
                           (insn_iter_in == 14'd0) || (insn_end <= insn_bgn);

  // Loop-boundary flags for the beat currently presented
  logic last_u, last_j, last_i, fire, last_beat;

  assign last_u    = (u_q == uop_end_q - UOP_ONE);
  assign last_j    = (j_q == iter_in_q - CNT_ONE);
  assign last_i    = (i_q == iter_out_q - CNT_ONE);
  assign fire      = (state_q == S_RUN) && out_ready;
  assign last_beat = (state_q == S_RUN) && last_u && last_j && last_i;

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge value of every other flop, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  // NOTE: a default assignment at the top of every always_comb keeps each
  // path fully specified so no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (insn_valid) state_d = insn_degenerate ? S_DONE : S_RUN;
      S_RUN:  if (fire && last_beat) state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Output logic
  // -------------------------------------------------------------------------
  always_comb begin
    insn_ready = (state_q == S_IDLE);
    out_valid  = (state_q == S_RUN);
    done       = (state_q == S_DONE);
    last       = last_beat;
  end

  assign uop_addr       = u_q;
  assign dst_offset_out = dst_out_q;
  assign dst_offset_in  = dst_in_q;
  assign src_offset_out = src_out_q;
  assign src_offset_in  = src_in_q;
  assign wgt_offset_out = wgt_out_q;
  assign wgt_offset_in  = wgt_in_q;
  assign reset_acc      = reset_acc_q;

  // -------------------------------------------------------------------------
  // Datapath next-value logic: instruction latch and loop counters
  // -------------------------------------------------------------------------
  always_comb begin
    uop_bgn_d   = uop_bgn_q;
    uop_end_d   = uop_end_q;
    iter_out_d  = iter_out_q;
    iter_in_d   = iter_in_q;
    dst_f_out_d = dst_f_out_q;
    dst_f_in_d  = dst_f_in_q;
    src_f_out_d = src_f_out_q;
    src_f_in_d  = src_f_in_q;
    wgt_f_out_d = wgt_f_out_q;
    wgt_f_in_d  = wgt_f_in_q;
    reset_acc_d = reset_acc_q;
    u_d         = u_q;
    i_d         = i_q;
    j_d         = j_q;
    dst_out_d   = dst_out_q;
    dst_in_d    = dst_in_q;
    src_out_d   = src_out_q;
    src_in_d    = src_in_q;
    wgt_out_d   = wgt_out_q;
    wgt_in_d    = wgt_in_q;

    if (state_q == S_IDLE && insn_valid) begin
      uop_bgn_d   = insn_bgn;
      uop_end_d   = insn_end;
      iter_out_d  = insn_iter_out;
      iter_in_d   = insn_iter_in;
      dst_f_out_d = insn[73:63];
      dst_f_in_d  = insn[84:74];
      src_f_out_d = insn[95:85];
      src_f_in_d  = insn[106:96];
      wgt_f_out_d = insn[116:107];
      wgt_f_in_d  = insn[126:117];
      reset_acc_d = insn[7];
      u_d         = insn_bgn;
      i_d         = 14'd0;
      j_d         = 14'd0;
      dst_out_d   = '0;
      dst_in_d    = '0;
      src_out_d   = '0;
      src_in_d    = '0;
      wgt_out_d   = '0;
      wgt_in_d    = '0;
    end else if (fire) begin
      if (!last_u) begin
        u_d = u_q + UOP_ONE;
      end else begin
        u_d = uop_bgn_q;
        if (!last_j) begin
          j_d      = j_q + CNT_ONE;
          dst_in_d = dst_in_q + dst_f_in_q;
          src_in_d = src_in_q + src_f_in_q;
          wgt_in_d = wgt_in_q + wgt_f_in_q;
        end else begin
          // Inner loop wraps: restart inner offsets, step the outer loop.
          j_d       = 14'd0;
          dst_in_d  = '0;
          src_in_d  = '0;
          wgt_in_d  = '0;
          i_d       = i_q + CNT_ONE;
          dst_out_d = dst_out_q + dst_f_out_q;
          src_out_d = src_out_q + src_f_out_q;
          wgt_out_d = wgt_out_q + wgt_f_out_q;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      uop_bgn_q   <= '0;
      uop_end_q   <= '0;
      iter_out_q  <= '0;
      iter_in_q   <= '0;
      dst_f_out_q <= '0;
      dst_f_in_q  <= '0;
      src_f_out_q <= '0;
      src_f_in_q  <= '0;
      wgt_f_out_q <= '0;
      wgt_f_in_q  <= '0;
      reset_acc_q <= 1'b0;
      u_q         <= '0;
      i_q         <= '0;
      j_q         <= '0;
      dst_out_q   <= '0;
      dst_in_q    <= '0;
      src_out_q   <= '0;
      src_in_q    <= '0;
      wgt_out_q   <= '0;
      wgt_in_q    <= '0;
    end else begin
      uop_bgn_q   <= uop_bgn_d;
      uop_end_q   <= uop_end_d;
      iter_out_q  <= iter_out_d;
      iter_in_q   <= iter_in_d;
      dst_f_out_q <= dst_f_out_d;
      dst_f_in_q  <= dst_f_in_d;
      src_f_out_q <= src_f_out_d;
      src_f_in_q  <= src_f_in_d;
      wgt_f_out_q <= wgt_f_out_d;
      wgt_f_in_q  <= wgt_f_in_d;
      reset_acc_q <= reset_acc_d;
      u_q         <= u_d;
      i_q         <= i_d;
      j_q         <= j_d;
      dst_out_q   <= dst_out_d;
      dst_in_q    <= dst_in_d;
      src_out_q   <= src_out_d;
      src_in_q    <= src_in_d;
      wgt_out_q   <= wgt_out_d;
      wgt_in_q    <= wgt_in_d;
    end
  end

endmodule
